mealy_stream_scheduler: RTL and testbench

//  Shares one bit-serial Mealy detector core among N_REQ requesters. Each request is a W-bit word.
//  The block arbitrates round-robin, clears the core to S0, and shifts the word in MSB first.
//  It collects the core's per-bit y output into a W-bit result and returns it on a valid/ready response port.
//  It sits between the packet front-end and the detect-statistics unit.

---
 rtl/mealy_pkg.sv | 17 +
 rtl/mealy_core.sv | 65 ++++++
 rtl/mealy_stream_scheduler.sv | 174 +++++++++++++++++
 tb/tb_mealy_stream_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mealy_pkg.sv
// Shared types for the Mealy stream scheduler: detector core states and controller states.
package mealy_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } core_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        RESP  = 2'b10
    } ctrl_state_t;

endpackage

// File: rtl/mealy_core.sv
// Bit-serial Mealy detector core; y is combinational from the current state and x.
//  state | meaning
//  S0    | cleared / start state
//  S1    | reached from S3 on a 1
//  S2    | after a 1 from S0/S1, or holding on 0s
//  S3    | after 1,1 from S2, holding on 0s
module mealy_core
    import mealy_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic y
);

    core_state_t state_q;
    core_state_t state_d;
    core_state_t step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        step = state_q;
        y    = 1'b0;
        case (state_q)
            S0: begin
                y    = x;
                step = x ? S2 : S0;
            end
            S1: begin
                y    = 1'b0;
                step = x ? S2 : S0;
            end
            S2: begin
                y    = ~x;
                step = x ? S3 : S2;
            end
            S3: begin
                y    = x;
                step = x ? S1 : S3;
            end
            default: begin
                y    = 1'b0;
                step = S0;
            end
        endcase

        // clear wins over enable
        state_d = state_q;
        if (clr) begin
            state_d = S0;
        end else if (en) begin
            state_d = step;
        end
    end

endmodule

// File: rtl/mealy_stream_scheduler.sv
// Round-robin scheduler feeding W-bit words MSB-first through one shared Mealy core.
//  state | meaning
//  IDLE  | arbitrating; grants one requester per cycle when any is valid
//  SHIFT | serialising the latched word through the core, W cycles
//  RESP  | holding the collected result until downstream accepts
module mealy_stream_scheduler
    import mealy_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int W     = 8,
    localparam int ID_W  = $clog2(N_REQ),
    localparam int CNT_W = $clog2(W + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*W-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    input  logic                 abort,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [W-1:0]         rsp_data,
    output logic [CNT_W-1:0]     rsp_ones,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

    ctrl_state_t state_q;
    ctrl_state_t state_d;

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  id_q;
    logic [W-1:0]     shift_q;
    logic [W-1:0]     result_q;
    logic [CNT_W-1:0] bit_cnt;

    logic [N_REQ-1:0] rotated;
    logic [ID_W-1:0]  pick;
    logic             found;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  next_ptr;
    logic [W-1:0]     grant_word;
    logic [CNT_W-1:0] ones;

    logic grant;
    logic core_clr;
    logic core_en;
    logic core_y;

    // Arbiter: rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rotated = '0;
        pick    = '0;
        found   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            logic [ID_W-1:0] src;
            src        = ID_W'((int'(rr_ptr) + i) % N_REQ);
            rotated[i] = req_valid[src];
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && rotated[i]) begin
                pick  = ID_W'(i);
                found = 1'b1;
            end
        end
        winner   = ID_W'((int'(pick) + int'(rr_ptr)) % N_REQ);
        next_ptr = ID_W'((int'(winner) + 1) % N_REQ);
    end

    always_comb begin
        grant_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                grant_word = req_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        grant     = 1'b0;
        core_clr  = 1'b0;
        core_en   = 1'b0;
        case (state_q)
            IDLE: begin
                // abort suppresses the grant; rst_n gating keeps outputs quiet in reset
                if (rst_n && !abort && found) begin
                    grant     = 1'b1;
                    req_ready = N_REQ'(1) << winner;
                    core_clr  = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    core_clr = 1'b1;
                    state_d  = IDLE;
                end else begin
                    core_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (abort) begin
                    core_clr = 1'b1;
                    state_d  = IDLE;
                end else if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                core_clr = 1'b1;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            id_q     <= '0;
            shift_q  <= '0;
            result_q <= '0;
            bit_cnt  <= '0;
        end else if (grant) begin
            rr_ptr   <= next_ptr;
            id_q     <= winner;
            shift_q  <= grant_word;
            result_q <= '0;
            bit_cnt  <= '0;
        end else if (core_en) begin
            shift_q  <= {shift_q[W-2:0], 1'b0};
            result_q <= {result_q[W-2:0], core_y};
            bit_cnt  <= bit_cnt + CNT_W'(1);
        end
    end

    mealy_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (core_clr),
        .en    (core_en),
        .x     (shift_q[W-1]),
        .y     (core_y)
    );

    always_comb begin
        ones = '0;
        for (int i = 0; i < W; i++) begin
            ones = ones + CNT_W'(result_q[i]);
        end
    end

    // Response fields read as zero outside RESP so stale results never leak.
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_valid ? id_q     : '0;
    assign rsp_data  = rsp_valid ? result_q : '0;
    assign rsp_ones  = rsp_valid ? ones     : '0;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mealy_stream_scheduler.sv
// Bench for mealy_stream_scheduler: directed scenarios plus random traffic against a job-level model.
module tb_mealy_stream_scheduler;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int ID_W  = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             abort;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [ID_W-1:0]  rsp_id;
    logic [W-1:0]     rsp_data;
    logic [CNT_W-1:0] rsp_ones;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    // model: phase 0 idle, 1 shifting, 2 holding a response
    int         m_phase = 0;
    int         m_left  = 0;
    int         m_rr    = 0;
    int         m_id    = 0;
    logic [W-1:0] m_res = '0;

    logic [N-1:0] seen_ready;

    always #5 clk = ~clk;

    mealy_stream_scheduler #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .abort     (abort),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ones  (rsp_ones),
        .busy      (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Whole-word detector response from the transition/output tables.
    function automatic logic [W-1:0] detect(input logic [W-1:0] word);
        int nxt_tab [4][2] = '{'{0, 2}, '{0, 2}, '{2, 3}, '{3, 1}};
        int y_tab   [4][2] = '{'{0, 1}, '{0, 0}, '{1, 0}, '{0, 1}};
        int s = 0;
        logic [W-1:0] res = '0;
        for (int i = W - 1; i >= 0; i--) begin
            int x = word[i] ? 1 : 0;
            res[i] = (y_tab[s][x] != 0);
            s = nxt_tab[s][x];
        end
        return res;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] rv);
        for (int k = 0; k < N; k++) begin
            if (rv[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    // One clock: apply inputs, compare every output with the model, advance the model on the edge.
    task automatic cycle(input logic [N-1:0] rv, input logic [N*W-1:0] rd,
                         input logic ab, input logic rdy, input logic rn);
        logic [N-1:0] exp_ready;
        logic         exp_valid;
        int           w;
        req_valid = rv;
        req_data  = rd;
        abort     = ab;
        rsp_ready = rdy;
        rst_n     = rn;
        #1;
        exp_ready = '0;
        w = rr_pick(rv);
        if (rn && !ab && m_phase == 0 && w >= 0) exp_ready[w] = 1'b1;
        exp_valid = (m_phase == 2);
        check_val("req_ready", 32'(req_ready), 32'(exp_ready));
        check_val("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        check_val("busy", 32'(busy), 32'(m_phase != 0));
        check_val("rsp_data", 32'(rsp_data), exp_valid ? 32'(m_res) : 32'd0);
        check_val("rsp_ones", 32'(rsp_ones), exp_valid ? 32'($countones(m_res)) : 32'd0);
        check_val("rsp_id", 32'(rsp_id), exp_valid ? 32'(m_id) : 32'd0);
        seen_ready = req_ready;
        @(posedge clk);
        if (!rn) begin
            m_phase = 0;
            m_rr    = 0;
        end else begin
            case (m_phase)
                0: if (!ab && w >= 0) begin
                    m_id    = w;
                    m_res   = detect(rd[w*W +: W]);
                    m_left  = W;
                    m_rr    = (w + 1) % N;
                    m_phase = 1;
                end
                1: if (ab) m_phase = 0;
                   else begin
                       m_left--;
                       if (m_left == 0) m_phase = 2;
                   end
                default: if (ab || rdy) m_phase = 0;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (busy && n < 4 * W) begin
            cycle('0, '0, 1'b0, 1'b1, 1'b1);
            n++;
        end
        check_val("drain_idle", 32'(busy), 32'd0);
    endtask

    task automatic run_job(input int idx, input logic [W-1:0] word, input logic [W-1:0] exp_d,
                           input int exp_o, input int hold);
        logic [N-1:0]   rv;
        logic [N*W-1:0] rd;
        int             lat = 0;
        rv = '0;
        rv[idx] = 1'b1;
        rd = $urandom;
        rd[idx*W +: W] = word;
        cycle(rv, rd, 1'b0, 1'b0, 1'b1);
        check_val("job_grant", 32'(seen_ready), 32'(rv));
        while (!rsp_valid && lat < 4 * W) begin
            cycle('0, rd, 1'b0, 1'b0, 1'b1);
            lat++;
        end
        check_val("job_latency", lat, W);
        check_val("job_data", 32'(rsp_data), 32'(exp_d));
        check_val("job_ones", 32'(rsp_ones), exp_o);
        check_val("job_id", 32'(rsp_id), idx);
        for (int h = 0; h < hold; h++) begin
            cycle('0, rd, 1'b0, 1'b0, 1'b1);
            check_val("hold_data", 32'(rsp_data), 32'(exp_d));
            check_val("hold_busy", 32'(busy), 32'd1);
        end
        cycle('0, rd, 1'b0, 1'b1, 1'b1);
        check_val("bubble_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int grants[$];
        int gtime[$];
        int t;
        logic [W-1:0] wd;

        req_valid = '0;
        req_data  = '0;
        abort     = 1'b0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle('0, '0, 1'b0, 1'b0, 1'b0);
        check_val("reset_busy", 32'(busy), 32'd0);

        // single requester, known words
        run_job(0, 8'b1011_0000, 8'b1101_0000, 3, 0);
        run_job(0, 8'hF0, 8'b1010_1111, 6, 0);

        // two requesters held valid: strict alternation with one bubble between jobs
        cycle('0, '0, 1'b0, 1'b0, 1'b0);
        t = 0;
        while (grants.size() < 4 && t < 80) begin
            cycle(4'b0101, 32'h3C5A_96E1, 1'b0, 1'b1, 1'b1);
            if (seen_ready != '0) begin
                grants.push_back(seen_ready == 4'b0001 ? 0 : (seen_ready == 4'b0100 ? 2 : 9));
                gtime.push_back(t);
            end
            t++;
        end
        check_val("rr_count", grants.size(), 4);
        if (grants.size() == 4) begin
            check_val("rr_order0", grants[0], 0);
            check_val("rr_order1", grants[1], 2);
            check_val("rr_order2", grants[2], 0);
            check_val("rr_order3", grants[3], 2);
            for (int k = 1; k < 4; k++) check_val("rr_period", gtime[k] - gtime[k-1], W + 2);
        end
        drain();

        // backpressure on the response
        wd = 8'h3D;
        run_job(1, wd, detect(wd), $countones(detect(wd)), 5);

        // abort mid-shift, then a fresh job must start from S0
        cycle(4'b0010, {4{8'hFF}}, 1'b0, 1'b0, 1'b1);
        repeat (3) cycle('0, '0, 1'b0, 1'b0, 1'b1);
        cycle('0, '0, 1'b1, 1'b0, 1'b1);
        check_val("abort_busy", 32'(busy), 32'd0);
        for (int k = 0; k < W + 2; k++) begin
            cycle('0, '0, 1'b0, 1'b1, 1'b1);
            check_val("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        wd = 8'h5A;
        run_job(1, wd, detect(wd), $countones(detect(wd)), 0);

        // reset during SHIFT: grant of 2 leaves rr_ptr at 3, reset must return it to 0
        cycle(4'b0100, $urandom, 1'b0, 1'b0, 1'b1);
        repeat (2) cycle('0, '0, 1'b0, 1'b0, 1'b1);
        cycle('0, '0, 1'b0, 1'b0, 1'b0);
        check_val("rst_shift_busy", 32'(busy), 32'd0);
        cycle(4'b1010, $urandom, 1'b0, 1'b1, 1'b1);
        check_val("rst_shift_grant", 32'(seen_ready), 32'b0010);
        drain();

        // reset during RESP
        cycle(4'b0100, $urandom, 1'b0, 1'b0, 1'b1);
        t = 0;
        while (!rsp_valid && t < 4 * W) begin
            cycle('0, '0, 1'b0, 1'b0, 1'b1);
            t++;
        end
        check_val("rst_resp_reach", 32'(rsp_valid), 32'd1);
        cycle('0, '0, 1'b0, 1'b0, 1'b0);
        check_val("rst_resp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_resp_data", 32'(rsp_data), 32'd0);
        cycle(4'b1010, $urandom, 1'b0, 1'b1, 1'b1);
        check_val("rst_resp_grant", 32'(seen_ready), 32'b0010);
        drain();

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            cycle(4'($urandom_range(0, 15)), $urandom,
                  ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 60),
                  ($urandom_range(0, 199) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
